// File: rtl/score_event_gen.sv
// score_event_gen: per-frame goal detection, stretched score-increment strobes,
// serve hold-off, game-over at the winning score and restart digit-clear sequencing.
module score_event_gen #(
  parameter int unsigned FIELD_XMIN     = 8,
  parameter int unsigned FIELD_XMAX     = 631,
  parameter int unsigned PULSE_W        = 4,
  parameter int unsigned HOLDOFF_FRAMES = 60,
  parameter int unsigned WIN_SCORE      = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [9:0] ball_x,
  input  logic       ball_valid,
  input  logic       restart,
  output logic       inc_left,
  output logic       inc_right,
  output logic       clr_n,
  output logic       serve,
  output logic       serve_dir,
  output logic       game_over,
  output logic [3:0] score_left,
  output logic [3:0] score_right
);

  localparam int unsigned XW  = 10;
  localparam int unsigned SW  = 4;
  localparam int unsigned PCW = (PULSE_W > 0) ? $clog2(PULSE_W + 1) : 1;
  localparam int unsigned HCW = (HOLDOFF_FRAMES > 0) ? $clog2(HOLDOFF_FRAMES + 1) : 1;

  localparam logic [PCW-1:0] PULSE_LAST = PCW'(PULSE_W);
  localparam logic [PCW-1:0] PULSE_ONE  = PCW'(1);
  localparam logic [HCW-1:0] HOLD_LAST  = HCW'(HOLDOFF_FRAMES);
  localparam logic [HCW-1:0] HOLD_ONE   = HCW'(1);
  localparam logic [XW-1:0]  XMIN       = XW'(FIELD_XMIN);
  localparam logic [XW-1:0]  XMAX       = XW'(FIELD_XMAX);
  localparam logic [SW-1:0]  WIN        = SW'(WIN_SCORE);
  localparam logic [SW-1:0]  SCORE_ONE  = SW'(1);

  typedef enum logic [2:0] {
    S_HOLDOFF,
    S_PLAY,
    S_PULSE,
    S_GAMEOVER,
    S_CLEAR
  } state_t;

  state_t         state, state_d;
  logic [PCW-1:0] pcnt, pcnt_d;
  logic [HCW-1:0] hcnt, hcnt_d;
  logic           scorer, scorer_d;  // 1 = left player scored
  logic [SW-1:0]  score_left_d, score_right_d;
  logic           inc_left_d, inc_right_d, clr_n_d, serve_d, serve_dir_d, game_over_d;

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_d       = state;
    pcnt_d        = pcnt;
    hcnt_d        = hcnt;
    scorer_d      = scorer;
    score_left_d  = score_left;
    score_right_d = score_right;
    serve_dir_d   = serve_dir;
    inc_left_d    = 1'b0;
    inc_right_d   = 1'b0;
    clr_n_d       = 1'b1;
    serve_d       = 1'b0;

    if (restart) begin
      state_d       = S_CLEAR;
      pcnt_d        = PULSE_ONE;
      score_left_d  = '0;
      score_right_d = '0;
      serve_dir_d   = 1'b0;
      clr_n_d       = 1'b0;
    end else begin
      unique case (state)
        S_HOLDOFF: begin
          if (hcnt == HOLD_LAST) begin
            serve_d = 1'b1;
            state_d = S_PLAY;
          end else if (frame_tick) begin
            hcnt_d = hcnt + HOLD_ONE;
          end
        end
        S_PLAY: begin
          if (frame_tick && ball_valid) begin
            if (ball_x < XMIN) begin
              scorer_d    = 1'b0;
              inc_right_d = 1'b1;
              pcnt_d      = PULSE_ONE;
              state_d     = S_PULSE;
            end else if (ball_x > XMAX) begin
              scorer_d   = 1'b1;
              inc_left_d = 1'b1;
              pcnt_d     = PULSE_ONE;
              state_d    = S_PULSE;
            end
          end
        end
        S_PULSE: begin
          // Strobe falls here; the shadow score tracks the digit's own count.
          if (pcnt == PULSE_LAST) begin
            hcnt_d = '0;
            if (scorer) begin
              score_left_d = score_left + SCORE_ONE;
              serve_dir_d  = 1'b1;
            end else begin
              score_right_d = score_right + SCORE_ONE;
              serve_dir_d   = 1'b0;
            end
            if ((scorer ? score_left_d : score_right_d) == WIN) begin
              state_d = S_GAMEOVER;
            end else begin
              state_d = S_HOLDOFF;
            end
          end else begin
            pcnt_d      = pcnt + PULSE_ONE;
            inc_left_d  = scorer;
            inc_right_d = ~scorer;
          end
        end
        S_GAMEOVER: begin
          state_d = S_GAMEOVER;
        end
        S_CLEAR: begin
          if (pcnt == PULSE_LAST) begin
            hcnt_d  = '0;
            state_d = S_HOLDOFF;
          end else begin
            pcnt_d  = pcnt + PULSE_ONE;
            clr_n_d = 1'b0;
          end
        end
        default: begin
          state_d = S_HOLDOFF;
        end
      endcase
    end

    game_over_d = (state_d == S_GAMEOVER);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_HOLDOFF;
      pcnt        <= '0;
      hcnt        <= '0;
      scorer      <= 1'b0;
      score_left  <= '0;
      score_right <= '0;
      serve_dir   <= 1'b0;
      inc_left    <= 1'b0;
      inc_right   <= 1'b0;
      clr_n       <= 1'b1;
      serve       <= 1'b0;
      game_over   <= 1'b0;
    end else begin
      state       <= state_d;
      pcnt        <= pcnt_d;
      hcnt        <= hcnt_d;
      scorer      <= scorer_d;
      score_left  <= score_left_d;
      score_right <= score_right_d;
      serve_dir   <= serve_dir_d;
      inc_left    <= inc_left_d;
      inc_right   <= inc_right_d;
      clr_n       <= clr_n_d;
      serve       <= serve_d;
      game_over   <= game_over_d;
    end
  end

endmodule

// File: tb/tb_score_event_gen.sv
// Bench for score_event_gen: directed steps plus random frames, every clock
// compared against a timer-based reference model of the scoring rules.
module tb_score_event_gen;

  localparam int unsigned XMIN = 8;
  localparam int unsigned XMAX = 631;
  localparam int unsigned PW   = 4;
  localparam int unsigned HF   = 2;
  localparam int unsigned WIN  = 9;

  logic       clk = 1'b0;
  logic       rst;
  logic       frame_tick;
  logic [9:0] ball_x;
  logic       ball_valid;
  logic       restart;
  logic       inc_left, inc_right, clr_n, serve, serve_dir, game_over;
  logic [3:0] score_left, score_right;

  int total = 0;
  int bad   = 0;

  // Reference model: remaining-time counters rather than named states.
  int m_inc_rem, m_clr_rem, m_wait, m_sl, m_sr;
  bit m_left, m_waiting, m_play, m_over, m_serve, m_dir;

  score_event_gen #(
    .FIELD_XMIN(XMIN), .FIELD_XMAX(XMAX), .PULSE_W(PW),
    .HOLDOFF_FRAMES(HF), .WIN_SCORE(WIN)
  ) dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .ball_x(ball_x),
    .ball_valid(ball_valid), .restart(restart), .inc_left(inc_left),
    .inc_right(inc_right), .clr_n(clr_n), .serve(serve), .serve_dir(serve_dir),
    .game_over(game_over), .score_left(score_left), .score_right(score_right)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_inc_rem = 0; m_clr_rem = 0; m_wait = HF; m_waiting = 1'b1;
    m_play = 1'b0; m_over = 1'b0; m_serve = 1'b0; m_dir = 1'b0;
    m_sl = 0; m_sr = 0; m_left = 1'b0;
  endtask

  task automatic model_step(input bit ft, input int bx, input bit bv, input bit rs);
    m_serve = 1'b0;
    if (rs) begin
      m_inc_rem = 0; m_clr_rem = PW; m_sl = 0; m_sr = 0; m_dir = 1'b0;
      m_over = 1'b0; m_play = 1'b0; m_waiting = 1'b0;
    end else if (m_clr_rem > 0) begin
      m_clr_rem--;
      if (m_clr_rem == 0) begin m_waiting = 1'b1; m_wait = HF; end
    end else if (m_inc_rem > 0) begin
      m_inc_rem--;
      if (m_inc_rem == 0) begin
        if (m_left) begin m_sl++; m_dir = 1'b1; end
        else begin m_sr++; m_dir = 1'b0; end
        if ((m_left ? m_sl : m_sr) == int'(WIN)) m_over = 1'b1;
        else begin m_waiting = 1'b1; m_wait = HF; end
      end
    end else if (m_waiting) begin
      if (m_wait == 0) begin m_serve = 1'b1; m_waiting = 1'b0; m_play = 1'b1; end
      else if (ft) m_wait--;
    end else if (m_play && ft && bv) begin
      if (bx < int'(XMIN)) begin m_left = 1'b0; m_inc_rem = PW; m_play = 1'b0; end
      else if (bx > int'(XMAX)) begin m_left = 1'b1; m_inc_rem = PW; m_play = 1'b0; end
    end
  endtask

  task automatic check_all();
    check("inc_left",    4'(inc_left),    4'(m_inc_rem > 0 && m_left));
    check("inc_right",   4'(inc_right),   4'(m_inc_rem > 0 && !m_left));
    check("clr_n",       4'(clr_n),       4'(m_clr_rem == 0));
    check("serve",       4'(serve),       4'(m_serve));
    check("serve_dir",   4'(serve_dir),   4'(m_dir));
    check("game_over",   4'(game_over),   4'(m_over));
    check("score_left",  score_left,      4'(m_sl));
    check("score_right", score_right,     4'(m_sr));
    check("inc_both",    4'(inc_left & inc_right), 4'd0);
    check("inc_clr_overlap", 4'((inc_left | inc_right) & ~clr_n), 4'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step(frame_tick, int'(ball_x), ball_valid, restart);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic frame(input logic [9:0] x, input logic v);
    frame_tick = 1'b1; ball_x = x; ball_valid = v;
    tick();
    frame_tick = 1'b0;
  endtask

  task automatic wait_play();
    int n = 0;
    while (!m_play && n < 50) begin
      frame(10'd320, 1'b1);
      idle(2);
      n++;
    end
    total++;
    assert (n < 50) else begin
      bad++;
      $error("FAIL wait_play observed=timeout expected=serve");
    end
  endtask

  initial begin
    int  n;
    bit  prev_ft;
    rst = 1'b1; frame_tick = 1'b0; ball_x = '0; ball_valid = 1'b0; restart = 1'b0;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    #9 rst = 1'b1;

    // T1: hold-off of two frames then serve toward the left
    idle(3);
    frame(10'd320, 1'b1);
    idle(1);
    frame(10'd320, 1'b1);
    tick();
    check("T1_serve", 4'(serve), 4'd1);
    check("T1_dir", 4'(serve_dir), 4'd0);
    idle(1);

    // T2: ball out on the left -> right player scores
    frame(10'd3, 1'b1);
    check("T2_inc_rise", 4'(inc_right), 4'd1);
    idle(PW - 1);
    check("T2_inc_last", 4'(inc_right), 4'd1);
    tick();
    check("T2_inc_fall", 4'(inc_right), 4'd0);
    check("T2_score", score_right, 4'd1);
    wait_play();
    frame(10'd3, 1'b0);
    idle(PW + 1);
    check("T2_invalid", score_right, 4'd1);

    // T3: left player runs up to the winning score
    n = 0;
    while (!m_over && n < 20) begin
      wait_play();
      frame(10'd700, 1'b1);
      idle(PW + 1);
      n++;
    end
    check("T3_score_left", score_left, 4'd9);
    check("T3_game_over", 4'(game_over), 4'd1);
    repeat (3) begin
      frame(10'd700, 1'b1);
      idle(3);
    end
    check("T3_no_more", score_left, 4'd9);

    // T4: restart from game over
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("T4_clr_low", 4'(clr_n), 4'd0);
    idle(PW + 1);
    check("T4_scores", score_left | score_right, 4'd0);
    check("T4_game_over", 4'(game_over), 4'd0);
    wait_play();

    // T5: restart two clocks into an inc_left pulse
    frame(10'd700, 1'b1);
    tick();
    check("T5_inc_mid", 4'(inc_left), 4'd1);
    restart = 1'b1;
    tick();
    restart = 1'b0;
    check("T5_inc_drop", 4'(inc_left), 4'd0);
    check("T5_clr", 4'(clr_n), 4'd0);
    idle(PW + 2);
    check("T5_score_left", score_left, 4'd0);

    // Random frames, ball positions and occasional restarts
    prev_ft = 1'b0;
    repeat (600) begin
      frame_tick = !prev_ft && ($urandom_range(3) == 0);
      prev_ft = frame_tick;
      case ($urandom_range(2))
        0:       ball_x = 10'($urandom_range(7));
        1:       ball_x = 10'($urandom_range(1023, 632));
        default: ball_x = 10'($urandom_range(631, 8));
      endcase
      ball_valid = ($urandom_range(3) != 0);
      restart = ($urandom_range(99) == 0);
      tick();
    end
    frame_tick = 1'b0; restart = 1'b0;
    idle(PW + 2);
    if (m_over) begin
      restart = 1'b1;
      tick();
      restart = 1'b0;
    end

    // T6: asynchronous reset in the middle of a pulse
    wait_play();
    frame(10'd0, 1'b1);
    tick();
    #3 rst = 1'b0;
    #1;
    model_reset();
    check_all();
    check("T6_inc_right", 4'(inc_right), 4'd0);
    #2 rst = 1'b1;
    wait_play();
    frame(10'd900, 1'b1);
    idle(PW + 2);
    check("T6_recover", score_left, 4'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
